// File: rtl/mhp_frame_engine.sv
// Frame receive/reply engine: drains one RX FIFO payload into a local buffer, ends it on an
// inter-byte gap, filters it by length and replays it after a hold-off with an optional 16-bit sum.
module mhp_frame_engine #(
    parameter int ADDR_W         = 10,
    parameter int GAP_CYCLES     = 63,
    parameter int MIN_LEN        = 1,
    parameter int HOLDOFF_CYCLES = 256
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    input  logic            i_cs_en,
    input  logic [7:0]      i_rdata,
    input  logic            i_rready,
    output logic            o_rreq,
    output logic [7:0]      o_wdata,
    input  logic            i_wready,
    output logic            o_wvalid,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_drop,
    output logic [15:0]     o_frame_cnt,
    output logic [ADDR_W:0] o_last_len
);
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = ADDR_W + 2;
    localparam int GAP_W  = $clog2(GAP_CYCLES);
    localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CAP   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_FETCH = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;
    localparam logic [2:0] S_NEXT  = 3'd7;

    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   MIN_LEN_L = (ADDR_W + 1)'(MIN_LEN);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [15:0]       sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  tot_q, tot_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]   last_len_q, last_len_d;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_q;
    logic              mem_we;
    logic              rreq;
    logic [CNT_W-1:0]  len_ext;
    logic [7:0]        tx_byte;

    assign mem_we  = (state_q == S_CAP) && (len_q < DEPTH_LEN);
    assign len_ext = {1'b0, len_q};
    // Payload bytes come from the buffer; the two bytes past the payload carry the sum, MSB first.
    assign tx_byte = (idx_q < len_ext)  ? rd_q :
                     (idx_q == len_ext) ? sum_q[15:8] : sum_q[7:0];

    // NOTE: the buffer is deliberately not reset; every location is written before it is read.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[len_q[ADDR_W-1:0]] <= i_rdata;
        end
        if (state_q == S_FETCH) begin
            rd_q <= mem[idx_q[ADDR_W-1:0]];
        end
    end

    always_comb begin
        // NOTE: every signal gets its default first, so no branch below can infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        gap_d      = gap_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        tot_d      = tot_q;
        wdata_d    = wdata_q;
        wvalid_d   = 1'b0;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        cnt_d      = cnt_q;
        last_len_d = last_len_q;
        rreq       = 1'b0;
        case (state_q)
            S_IDLE: begin
                len_d = '0;
                sum_d = '0;
                ovf_d = 1'b0;
                gap_d = '0;
                if (i_en && i_rready) begin
                    rreq    = 1'b1;
                    state_d = S_CAP;
                end
            end
            S_CAP: begin
                if (len_q < DEPTH_LEN) begin
                    len_d = len_q + (ADDR_W + 1)'(1);
                    sum_d = sum_q + {8'h00, i_rdata};
                end else begin
                    ovf_d = 1'b1;
                end
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (i_rready) begin
                    rreq    = 1'b1;
                    state_d = S_CAP;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_d == GAP_LAST) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                last_len_d = len_q;
                idx_d      = '0;
                hold_d     = '0;
                if (ovf_q || (len_q < MIN_LEN_L)) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tot_d   = len_ext + (i_cs_en ? CNT_W'(2) : CNT_W'(0));
                    state_d = (HOLDOFF_CYCLES == 0) ? S_FETCH : S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (i_wready) begin
                    wvalid_d = 1'b1;
                    wdata_d  = tx_byte;
                    state_d  = S_NEXT;
                end
            end
            S_NEXT: begin
                idx_d = idx_q + CNT_W'(1);
                if (idx_d == tot_q) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values in parallel.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            gap_q      <= '0;
            hold_q     <= '0;
            idx_q      <= '0;
            tot_q      <= '0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            last_len_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            gap_q      <= gap_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
            tot_q      <= tot_d;
            wdata_q    <= wdata_d;
            wvalid_q   <= wvalid_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            last_len_q <= last_len_d;
        end
    end

    // The read strobe pops the FIFO at the edge ending IDLE/GAP, so CAP sees the byte the cycle after.
    assign o_rreq      = rreq & i_rst_n;
    assign o_wdata     = wdata_q;
    assign o_wvalid    = wvalid_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_drop      = drop_q;
    assign o_frame_cnt = cnt_q;
    assign o_last_len  = last_len_q;

endmodule

// File: tb/tb_mhp_frame_engine.sv
// Self-checking bench for mhp_frame_engine: a queue-backed RX FIFO, table vectors, random frames
// against a frame-level reference model, plus backpressure and reset corner sequences.
module tb_mhp_frame_engine;
    localparam int ADDR_W  = 4;
    localparam int DEPTH   = 16;
    localparam int GAP     = 4;
    localparam int MIN_LEN = 3;
    localparam int HOLD    = 5;

    logic              clk = 1'b0;
    logic              rst_n, en, cs_en, rready, wready;
    logic [7:0]        rdata;
    logic              o_rreq, o_wvalid, o_busy, o_done, o_drop;
    logic [7:0]        o_wdata;
    logic [15:0]       o_frame_cnt;
    logic [ADDR_W:0]   o_last_len;

    always #5 clk = ~clk;

    mhp_frame_engine #(
        .ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .MIN_LEN(MIN_LEN), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_cs_en(cs_en),
        .i_rdata(rdata), .i_rready(rready), .o_rreq(o_rreq), .o_wdata(o_wdata),
        .i_wready(wready), .o_wvalid(o_wvalid), .o_busy(o_busy), .o_done(o_done),
        .o_drop(o_drop), .o_frame_cnt(o_frame_cnt), .o_last_len(o_last_len)
    );

    typedef struct {
        int          len;
        logic [31:0] head;
        bit          cs;
        bit          drop;
        int          last;
        logic [15:0] sum;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [7:0]  rxq[$];
    bit          stall_en = 1'b0;
    int          stall_left = 0;
    bit          wr_rand = 1'b0;
    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    logic [7:0]  exp_tx[$];
    int          rreq_n, first_rreq_cyc, last_rreq_cyc, done_n, done_cyc, drop_n, drop_cyc;
    int          cur_len;
    bit          finished;
    logic [15:0] exp_cnt = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then model the FIFO and sink just after the edge.
    task automatic tick();
        bit rreq_s;
        @(negedge clk);
        rreq_s = o_rreq;
        if (o_rreq) begin
            if (rreq_n == 0) first_rreq_cyc = cyc;
            rreq_n++;
            last_rreq_cyc = cyc;
        end
        if (o_wvalid) begin
            tx_log.push_back(o_wdata);
            tx_cyc.push_back(cyc);
        end
        if (o_done) begin done_n++; done_cyc = cyc; end
        if (o_drop) begin drop_n++; drop_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        if (rreq_s && rxq.size() > 0) begin
            rdata = rxq.pop_front();
            stall_left = stall_en ? int'($urandom_range(GAP - 2, 0)) : 0;
        end else begin
            rdata = 8'($urandom);
            if (stall_left > 0) stall_left--;
        end
        rready = (rxq.size() > 0) && (stall_left == 0);
        if (wr_rand) wready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic clear_logs();
        rreq_n = 0; done_n = 0; drop_n = 0;
        first_rreq_cyc = -1; last_rreq_cyc = -1; done_cyc = -1; drop_cyc = -1;
        tx_log.delete();
        tx_cyc.delete();
    endtask

    // Reference model: frame-level rules only (length filter, saturation, byte sum).
    task automatic build_expect(input logic [7:0] b[$], input bit cs, output bit edrop, output int elast);
        int sum = 0;
        exp_tx.delete();
        edrop = (b.size() < MIN_LEN) || (b.size() > DEPTH);
        elast = (b.size() > DEPTH) ? DEPTH : b.size();
        foreach (b[i]) sum = (sum + int'(b[i])) % 65536;
        if (!edrop) begin
            foreach (b[i]) exp_tx.push_back(b[i]);
            if (cs) begin
                exp_tx.push_back(8'(sum / 256));
                exp_tx.push_back(8'(sum % 256));
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b[$], input bit cs, input bit en_mid, input bit preload);
        clear_logs();
        cur_len = b.size();
        cs_en = cs;
        en = 1'b1;
        if (!preload) begin
            foreach (b[i]) rxq.push_back(b[i]);
            stall_left = 0;
            rready = 1'b1;
        end
        finished = 1'b0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            tick();
            if (rreq_n > 0 && en_mid) en = 1'b0;
            if (tx_log.size() > 0) cs_en = ~cs;
            if (done_n > 0 || drop_n > 0) finished = 1'b1;
        end
        repeat (4) tick();
        en = 1'b1;
        cs_en = cs;
    endtask

    task automatic verify(input string tag, input bit edrop, input int elast, input bit timing);
        int n;
        check({tag, "_finished"}, finished, 1);
        check({tag, "_drop_pulses"}, drop_n, edrop ? 1 : 0);
        check({tag, "_done_pulses"}, done_n, edrop ? 0 : 1);
        if (!edrop) exp_cnt = exp_cnt + 16'd1;
        check({tag, "_last_len"}, o_last_len, elast);
        check({tag, "_frame_cnt"}, o_frame_cnt, exp_cnt);
        check({tag, "_rreq_count"}, rreq_n, cur_len);
        check({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
        n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_tx_byte%0d", tag, i), tx_log[i], exp_tx[i]);
        check({tag, "_busy_after"}, o_busy, 0);
        if (timing) begin
            if (edrop) begin
                check({tag, "_drop_latency"}, drop_cyc, last_rreq_cyc + GAP + 2);
            end else if (tx_cyc.size() > 0) begin
                check({tag, "_first_tx_latency"}, tx_cyc[0], last_rreq_cyc + GAP + HOLD + 4);
                for (int i = 1; i < tx_cyc.size(); i++)
                    check($sformatf("%s_tx_spacing%0d", tag, i), tx_cyc[i] - tx_cyc[i-1], 3);
                check({tag, "_done_latency"}, done_cyc, tx_cyc[tx_cyc.size()-1] + 1);
            end
        end
    endtask

    initial begin
        vec_t        vecs[7];
        logic [7:0]  b[$];
        bit          edrop;
        int          elast;
        int          rel_cyc;

        rst_n = 1'b0; en = 1'b1; cs_en = 1'b0; rready = 1'b0; wready = 1'b1; rdata = 8'h00;
        clear_logs();

        // Reset held with a frame already waiting: no read strobe, all outputs zero.
        b = '{8'h3C, 8'h4D, 8'h5E};
        foreach (b[i]) rxq.push_back(b[i]);
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_ctrl_outputs%0d", i), {o_rreq, o_wvalid, o_busy, o_done, o_drop}, 0);
            check($sformatf("rst_data_outputs%0d", i), {o_wdata, o_frame_cnt, o_last_len}, 0);
        end
        check("rst_no_rreq", rreq_n, 0);
        rst_n = 1'b1;
        rel_cyc = cyc;
        run_frame(b, 1'b0, 1'b0, 1'b1);
        check("rst_rreq_first_cycle", first_rreq_cyc, rel_cyc);
        build_expect(b, 1'b0, edrop, elast);
        verify("rst_frame", edrop, elast, 1'b1);

        // Table vectors: byte i is taken from head for i<4, otherwise equals i.
        vecs[0] = '{3,  32'h11223300, 1'b0, 1'b0, 3,  16'h0066};
        vecs[1] = '{3,  32'hFFFF0300, 1'b1, 1'b0, 3,  16'h0201};
        vecs[2] = '{2,  32'hAABB0000, 1'b0, 1'b1, 2,  16'h0000};
        vecs[3] = '{16, 32'h00010203, 1'b1, 1'b0, 16, 16'h0078};
        vecs[4] = '{17, 32'h00010203, 1'b0, 1'b1, 16, 16'h0000};
        vecs[5] = '{3,  32'h01020300, 1'b0, 1'b0, 3,  16'h0006};
        vecs[6] = '{1,  32'h99000000, 1'b1, 1'b1, 1,  16'h0000};
        for (int v = 0; v < 7; v++) begin
            b.delete();
            for (int i = 0; i < vecs[v].len; i++)
                b.push_back((i < 4) ? vecs[v].head[31 - 8*i -: 8] : 8'(i));
            exp_tx.delete();
            if (!vecs[v].drop) begin
                foreach (b[i]) exp_tx.push_back(b[i]);
                if (vecs[v].cs) begin
                    exp_tx.push_back(vecs[v].sum[15:8]);
                    exp_tx.push_back(vecs[v].sum[7:0]);
                end
            end
            run_frame(b, vecs[v].cs, v[0], 1'b0);
            verify($sformatf("vec%0d", v), vecs[v].drop, vecs[v].last, 1'b1);
        end

        // Random frames with RX stalls shorter than the gap and random TX backpressure.
        stall_en = 1'b1;
        wr_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            bit cs;
            b.delete();
            for (int i = 0; i < int'($urandom_range(DEPTH + 2, 1)); i++) b.push_back(8'($urandom));
            cs = 1'($urandom);
            build_expect(b, cs, edrop, elast);
            run_frame(b, cs, 1'($urandom), 1'b0);
            verify($sformatf("rand%0d", f), edrop, elast, 1'b0);
        end
        stall_en = 1'b0;
        wr_rand = 1'b0;
        wready = 1'b1;

        // Backpressure: sink stalls for 10 cycles before the second byte.
        b = '{8'h5A, 8'hC3, 8'h7E};
        build_expect(b, 1'b0, edrop, elast);
        clear_logs();
        cur_len = b.size();
        cs_en = 1'b0;
        foreach (b[i]) rxq.push_back(b[i]);
        rready = 1'b1;
        for (int k = 0; k < 500 && tx_log.size() == 0; k++) tick();
        wready = 1'b0;
        repeat (10) tick();
        check("bp_no_wvalid_while_stalled", tx_log.size(), 1);
        check("bp_busy_while_stalled", o_busy, 1);
        wready = 1'b1;
        for (int k = 0; k < 500 && done_n == 0; k++) tick();
        repeat (3) tick();
        finished = (done_n > 0);
        verify("bp", edrop, elast, 1'b0);

        // Reset in the middle of a reply: outputs clear, no done, nothing more is sent.
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        clear_logs();
        foreach (b[i]) rxq.push_back(b[i]);
        rready = 1'b1;
        for (int k = 0; k < 500 && tx_log.size() < 2; k++) tick();
        rst_n = 1'b0;
        tick();
        check("rtx_ctrl_outputs", {o_rreq, o_wvalid, o_busy, o_done, o_drop}, 0);
        check("rtx_data_outputs", {o_wdata, o_frame_cnt, o_last_len}, 0);
        tick();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        repeat (40) tick();
        check("rtx_no_done", done_n, 0);
        check("rtx_no_drop", drop_n, 0);
        check("rtx_tx_count", tx_log.size(), 2);
        check("rtx_frame_cnt", o_frame_cnt, exp_cnt);
        check("rtx_idle", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
